// File: rtl/layer_output_serializer.sv
// Buffers a dense layer's result vector on each rising edge of vector_ready
// and streams it out one element per valid/accept handshake.
module layer_output_serializer #(
    parameter int WIDTH  = 32,
    parameter int LENGTH = 16,
    localparam int INDEX_WIDTH = $clog2(LENGTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   vector_ready,
    input  logic [WIDTH-1:0]       vector [LENGTH],
    output logic [WIDTH-1:0]       word,
    output logic [INDEX_WIDTH-1:0] word_index,
    output logic                   word_valid,
    input  logic                   word_accept,
    output logic                   last,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [INDEX_WIDTH-1:0] last_index = INDEX_WIDTH'(LENGTH - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] buffer [LENGTH];
    logic             vector_ready_q;
    logic             rise;
    logic             handshake;
    logic             final_handshake;

    assign rise            = vector_ready & ~vector_ready_q;
    assign handshake       = word_valid & word_accept;
    assign final_handshake = handshake & (word_index == last_index);

    // Outputs decode only from registers; vector never reaches them directly.
    assign word_valid = (state == STREAM);
    assign busy       = word_valid;
    assign last       = word_valid & (word_index == last_index);
    assign word       = buffer[word_index];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            word_index     <= '0;
            overrun        <= 1'b0;
            vector_ready_q <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            vector_ready_q <= vector_ready;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        buffer     <= vector;
                        word_index <= '0;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (final_handshake) begin
                        word_index <= '0;
                        // A result landing on the last handshake chains with no bubble.
                        if (rise) begin
                            buffer <= vector;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (handshake) begin
                            word_index <= word_index + 1'b1;
                        end
                        if (rise) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Self-checking bench for layer_output_serializer: vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_layer_output_serializer;

    localparam int W = 32;
    localparam int L = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         vector_ready = 1'b0;
    logic         word_accept = 1'b0;
    logic [W-1:0] vector [L];
    logic [W-1:0] word;
    logic [3:0]   word_index;
    logic         word_valid;
    logic         last;
    logic         busy;
    logic         overrun;

    always #5 clock = ~clock;

    layer_output_serializer #(.WIDTH(W), .LENGTH(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .vector_ready (vector_ready),
        .vector       (vector),
        .word         (word),
        .word_index   (word_index),
        .word_valid   (word_valid),
        .word_accept  (word_accept),
        .last         (last),
        .busy         (busy),
        .overrun      (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of words still owed to the consumer.
    typedef struct {
        logic [W-1:0] data;
        int           idx;
    } item_t;

    item_t mq[$];
    bit    m_prev;
    bit    m_ovr;

    typedef struct {
        bit           rdy;
        bit           acc;
        int           base;
        bit           e_valid;
        int           e_idx;
        logic [W-1:0] e_word;
        bit           e_last;
        bit           e_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_prev = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge();
        bit rise;
        bit hs;
        item_t it;
        rise   = vector_ready && !m_prev;
        hs     = (mq.size() > 0) && word_accept;
        m_prev = vector_ready;
        if (hs) void'(mq.pop_front());
        if (rise) begin
            if (mq.size() == 0) begin
                for (int i = 0; i < L; i++) begin
                    it.data = vector[i];
                    it.idx  = i;
                    mq.push_back(it);
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(string tag);
        bit v;
        v = mq.size() > 0;
        cmp({tag, ".valid"}, 64'(word_valid), 64'(v));
        cmp({tag, ".busy"}, 64'(busy), 64'(v));
        cmp({tag, ".last"}, 64'(last), 64'(mq.size() == 1));
        cmp({tag, ".overrun"}, 64'(overrun), 64'(m_ovr));
        cmp({tag, ".index"}, 64'(word_index), 64'(v ? mq[0].idx : 0));
        if (v) cmp({tag, ".word"}, 64'(word), 64'(mq[0].data));
    endtask

    task automatic set_vec(int base);
        for (int i = 0; i < L; i++) vector[i] = W'(base + i);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        vector_ready = 1'b0;
        word_accept  = 1'b0;
        model_clear();
        #1;
        cmp("rst.valid", 64'(word_valid), 64'd0);
        cmp("rst.busy", 64'(busy), 64'd0);
        cmp("rst.overrun", 64'(overrun), 64'd0);
        cmp("rst.index", 64'(word_index), 64'd0);
        cmp("rst.word", 64'(word), 64'd0);
        cmp("rst.last", 64'(last), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int cyc;
        vec_t e;
        set_vec(0);

        // Cycle-by-cycle vectors for the basic stream and a capture/hold.
        for (int k = 0; k < L; k++)
            tbl.push_back('{1, 1, 0, 1, k, W'(k), k == L - 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 'x, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 'x, 0, 0});
        tbl.push_back('{1, 0, 200, 1, 0, 200, 0, 0});
        tbl.push_back('{1, 0, 200, 1, 0, 200, 0, 0});
        tbl.push_back('{1, 1, 200, 1, 1, 201, 0, 0});

        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            e = tbl[k];
            vector_ready = e.rdy;
            word_accept  = e.acc;
            set_vec(e.base);
            step();
            cmp($sformatf("tbl%0d.valid", k), 64'(word_valid), 64'(e.e_valid));
            cmp($sformatf("tbl%0d.index", k), 64'(word_index), 64'(e.e_idx));
            cmp($sformatf("tbl%0d.last", k), 64'(last), 64'(e.e_last));
            cmp($sformatf("tbl%0d.overrun", k), 64'(overrun), 64'(e.e_ovr));
            if (e.e_valid) cmp($sformatf("tbl%0d.word", k), 64'(word), 64'(e.e_word));
        end

        // Accept toggling 1,0,1,0: 32 cycles including the capture edge.
        do_reset();
        set_vec(0);
        vector_ready = 1'b1;
        step();
        check_model("tog");
        cyc = 1;
        while (busy && cyc < 100) begin
            word_accept = (cyc % 2) == 1;
            step();
            check_model("tog");
            cyc++;
        end
        cmp("tog.cycles", 64'(cyc), 64'd32);

        // Held-high ready must not restart the stream.
        word_accept = 1'b1;
        repeat (100) begin
            step();
            check_model("hold");
        end
        vector_ready = 1'b0;
        step();
        set_vec(100);
        vector_ready = 1'b1;
        step();
        cmp("rerise.word", 64'(word), 64'd100);
        vector_ready = 1'b0;

        // Re-raise exactly on the final handshake.
        for (int i = 0; i < 40 && word_index != 4'd15; i++) begin
            step();
            check_model("b2b");
        end
        cmp("b2b.at15", 64'(word_index), 64'd15);
        set_vec(200);
        vector_ready = 1'b1;
        step();
        cmp("b2b.word", 64'(word), 64'd200);
        cmp("b2b.index", 64'(word_index), 64'd0);
        cmp("b2b.valid", 64'(word_valid), 64'd1);
        cmp("b2b.overrun", 64'(overrun), 64'd0);

        // Rise mid-stream at index 5 is dropped and flags overrun.
        vector_ready = 1'b0;
        for (int i = 0; i < 40 && word_index != 4'd5; i++) begin
            step();
            check_model("ovr");
        end
        cmp("ovr.at5", 64'(word_index), 64'd5);
        word_accept = 1'b0;
        set_vec(300);
        vector_ready = 1'b1;
        step();
        cmp("ovr.flag", 64'(overrun), 64'd1);
        cmp("ovr.word", 64'(word), 64'd205);
        word_accept = 1'b1;
        for (int i = 0; i < 40 && busy; i++) begin
            step();
            check_model("ovr");
        end
        cmp("ovr.idle", 64'(word_valid), 64'd0);

        // Asynchronous reset mid-stream at index 7.
        vector_ready = 1'b0;
        step();
        set_vec(0);
        vector_ready = 1'b1;
        step();
        for (int i = 0; i < 40 && word_index != 4'd7; i++) step();
        cmp("arst.at7", 64'(word_index), 64'd7);
        #2;
        reset = 1'b0;
        #1;
        cmp("arst.valid", 64'(word_valid), 64'd0);
        cmp("arst.busy", 64'(busy), 64'd0);
        cmp("arst.overrun", 64'(overrun), 64'd0);
        model_clear();
        set_vec(400);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        check_model("arst");
        cmp("arst.word", 64'(word), 64'd400);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) vector_ready = ~vector_ready;
            word_accept = $urandom_range(0, 3) != 0;
            for (int i = 0; i < L; i++) vector[i] = $urandom;
            step();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
